clock_enable_monitor: RTL and testbench
=======================================

CLOCK_ENABLE_MONITOR -- requirements
Module: clock_enable_monitor

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 12_000_000, source clock frequency in Hz.
REQ-002 SHALL have parameter COUNTER_FREQ, default 6_000_000, expected enable-pulse rate in Hz.
REQ-003 SHALL have parameter TOLERANCE, default 0, allowed period deviation in clk cycles, either direction.
REQ-004 SHALL have parameter LOCK_COUNT, default 4, number of consecutive in-range periods required for lock.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on posedge clk.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port en, input, 1, clock-enable pulse stream under test, synchronous to clk.
REQ-008 SHALL have port clear, input, 1, synchronous fault acknowledge.
REQ-009 SHALL have port period, output, W, last measured period in clk cycles.
REQ-010 SHALL have port period_valid, output, 1, one-cycle strobe marking a period update.
REQ-011 SHALL have port locked, output, 1, high while the stream is in tolerance.
REQ-012 SHALL have port fault, output, 1, sticky loss-of-lock flag.

Function
REQ-013 SHALL derive TICKS = CLK_FREQ / COUNTER_FREQ (integer), HI = TICKS + TOLERANCE, LO = TICKS - TOLERANCE, and W = $clog2(HI + 2).
REQ-014 SHALL keep counter cnt[W-1:0]: cnt is loaded with 0 in any cycle with en = 1, else incremented and saturated at HI.
REQ-015 SHALL measure a period of cnt + 1 (cnt sampled before update) on each en = 1 cycle; in range means LO <= period <= HI.
REQ-016 SHALL raise timeout when en = 0 and cnt == HI - 1; this is the earliest cycle at which the next period is certain to exceed HI.
REQ-017 SHALL implement the states SEARCH, MEASURE, LOCKED and FAULT, with a good-period counter good of $clog2(LOCK_COUNT + 1) bits.
REQ-018 SHALL, in SEARCH, move to MEASURE with good = 0 on the first en; no period_valid in this state.
REQ-019 SHALL, in MEASURE, increment good on an in-range en; when good reaches LOCK_COUNT, go to LOCKED.
REQ-020 SHALL, in MEASURE, set good = 0 and stay in MEASURE on an out-of-range en.
REQ-021 SHALL, in MEASURE, go to SEARCH on timeout.
REQ-022 SHALL, in LOCKED, go to FAULT on an out-of-range en or on timeout.
REQ-023 SHALL, in FAULT, hold until clear = 1, then go to SEARCH; en in the same cycle is ignored.
REQ-024 SHALL ignore clear in every state other than FAULT.
REQ-025 SHALL register period and pulse period_valid for one cycle, the cycle after each en sampled in MEASURE, LOCKED or FAULT.
REQ-026 SHALL register locked and fault, decoded from the state (LOCKED, FAULT), valid the cycle after the transition.
REQ-027 SHALL report period = HI + 1 when the saturated count yields an overlong period.
REQ-028 SHALL require COUNTER_FREQ <= CLK_FREQ, TOLERANCE < TICKS and LOCK_COUNT >= 1; other settings are unsupported.

Reset
REQ-029 SHALL, while rst = 1, immediately force state SEARCH, cnt = 0, good = 0, period = 0, period_valid = 0, locked = 0, fault = 0.
REQ-030 SHALL abandon any measurement in progress on rst assertion; after release the first en is treated as a new reference.

Configuration
REQ-031 SHALL provide macro CLOCK_ENABLE_MONITOR_FAULT_COUNT_EN.
REQ-032 SHALL, with the macro defined, add output fault_count[7:0]: incremented on each LOCKED->FAULT transition, saturating at 255, cleared only by rst (reset value 0).
REQ-033 SHALL, with the macro undefined, have no fault_count port and no associated logic.

Verification
REQ-034 SHALL cover: CLK_FREQ=12M, COUNTER_FREQ=3M (TICKS=4), TOLERANCE=0, LOCK_COUNT=4, en every 4 cycles -> period_valid with period=4 from the 2nd en on; locked=1 the cycle after the 5th en.
REQ-035 SHALL cover: locked, then en withheld 5 cycles -> timeout at cnt=3, fault=1 and locked=0 one cycle later.
REQ-036 SHALL cover: locked, next en after 3 cycles -> period=3, fault=1; with the macro defined, fault_count=1.
REQ-037 SHALL cover: in FAULT, assert clear together with en -> SEARCH, fault=0 next cycle, no period_valid; relock after 5 further good pulses.
REQ-038 SHALL cover: rst asserted mid-MEASURE, between clock edges -> all outputs 0 without waiting for a clk edge.
REQ-039 SHALL cover: COUNTER_FREQ=CLK_FREQ (TICKS=1), en held high -> locked after 5 cycles; a single en=0 cycle -> fault=1.

Source files
------------

// File: rtl/clock_enable_monitor.sv
// clock_enable_monitor: measures the spacing of a clock-enable pulse stream,
// declares lock after LOCK_COUNT consecutive in-tolerance periods and raises
// a sticky fault when a locked stream drifts out of range or stalls.
// Optional feature: define CLOCK_ENABLE_MONITOR_FAULT_COUNT_EN to add a
// saturating count of LOCKED->FAULT events on output fault_count.
module clock_enable_monitor #(
  parameter int CLK_FREQ     = 12_000_000,
  parameter int COUNTER_FREQ = 6_000_000,
  parameter int TOLERANCE    = 0,
  parameter int LOCK_COUNT   = 4,
  localparam int TICKS = CLK_FREQ / COUNTER_FREQ,
  localparam int HI    = TICKS + TOLERANCE,
  localparam int LO    = TICKS - TOLERANCE,
  localparam int W     = $clog2(HI + 2)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clear,
  output logic [W-1:0] period,
  output logic         period_valid,
  output logic         locked,
  output logic         fault
`ifdef CLOCK_ENABLE_MONITOR_FAULT_COUNT_EN
  ,
  output logic [7:0]   fault_count
`endif
);

  localparam int GW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [W-1:0]    cnt;
  logic [W-1:0]    meas;
  logic [GW-1:0]   good;
  logic [GW-1:0]   good_n;
  logic [GW-1:0]   good_inc;
  logic            in_range;
  logic            timeout;
  logic            upd;

  // Cycle counter stops at HI so an overlong gap reads back as HI + 1.
  function automatic logic [W-1:0] cnt_sat_inc(input logic [W-1:0] v);
    return (v == W'(HI)) ? v : v + W'(1);
  endfunction

  // Interval ending in this cycle; never wraps because cnt <= HI.
  assign meas     = cnt + W'(1);
  assign in_range = (meas >= W'(LO)) && (meas <= W'(HI));
  // One cycle earlier than an en could still land on HI: the next period is
  // already guaranteed to be too long.
  assign timeout  = !en && (cnt == W'(HI - 1));
  assign good_inc = good + GW'(1);

  // Period counter, restarted by every enable pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_sat_inc(cnt);
    end
  end

  // Next-state, good-period tracking and period-update decision.
  always_comb begin
    state_n = state;
    good_n  = good;
    upd     = 1'b0;
    case (state)
      SEARCH: begin
        if (en) begin
          state_n = MEASURE;
          good_n  = '0;
        end
      end
      MEASURE: begin
        if (timeout) begin
          state_n = SEARCH;
          good_n  = '0;
        end else if (en) begin
          upd = 1'b1;
          if (in_range) begin
            good_n = good_inc;
            if (good_inc == GW'(LOCK_COUNT)) state_n = LOCKED;
          end else begin
            good_n = '0;
          end
        end
      end
      LOCKED: begin
        upd = en;
        if (timeout || (en && !in_range)) state_n = FAULT;
      end
      FAULT: begin
        // Acknowledge wins over a coincident pulse; that pulse is dropped.
        if (clear) state_n = SEARCH;
        else       upd     = en;
      end
      default: begin
        state_n = SEARCH;
        good_n  = '0;
      end
    endcase
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= SEARCH;
      good         <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state        <= state_n;
      good         <= good_n;
      period_valid <= upd;
      if (upd) period <= meas;
      locked       <= (state_n == LOCKED);
      fault        <= (state_n == FAULT);
    end
  end

`ifdef CLOCK_ENABLE_MONITOR_FAULT_COUNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Loss-of-lock event counter, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_count <= 8'd0;
    end else if ((state == LOCKED) && (state_n == FAULT)) begin
      fault_count <= sat_inc8(fault_count);
    end
  end
`endif

endmodule

// File: tb/tb_clock_enable_monitor.sv
// Bench for clock_enable_monitor: three instances (TICKS=4 strict, TICKS=1,
// TICKS=4 with tolerance 1) driven by directed and random pulse streams and
// compared each cycle with a period/lock reference model.
module tb_clock_enable_monitor;

  logic clk = 1'b0;
  logic rst;
  logic en_v [3];
  logic clr_v [3];

  logic [2:0] period0;
  logic [1:0] period1;
  logic [2:0] period2;
  logic       pv0, pv1, pv2;
  logic       lk0, lk1, lk2;
  logic       ft0, ft1, ft2;
`ifdef CLOCK_ENABLE_MONITOR_FAULT_COUNT_EN
  logic [7:0] fc0, fc1, fc2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clock_enable_monitor #(.CLK_FREQ(12_000_000), .COUNTER_FREQ(3_000_000),
                         .TOLERANCE(0), .LOCK_COUNT(4)) dut0 (
    .clk(clk), .rst(rst), .en(en_v[0]), .clear(clr_v[0]), .period(period0),
    .period_valid(pv0), .locked(lk0), .fault(ft0)
`ifdef CLOCK_ENABLE_MONITOR_FAULT_COUNT_EN
    , .fault_count(fc0)
`endif
  );

  clock_enable_monitor #(.CLK_FREQ(12_000_000), .COUNTER_FREQ(12_000_000),
                         .TOLERANCE(0), .LOCK_COUNT(4)) dut1 (
    .clk(clk), .rst(rst), .en(en_v[1]), .clear(clr_v[1]), .period(period1),
    .period_valid(pv1), .locked(lk1), .fault(ft1)
`ifdef CLOCK_ENABLE_MONITOR_FAULT_COUNT_EN
    , .fault_count(fc1)
`endif
  );

  clock_enable_monitor #(.CLK_FREQ(12_000_000), .COUNTER_FREQ(3_000_000),
                         .TOLERANCE(1), .LOCK_COUNT(2)) dut2 (
    .clk(clk), .rst(rst), .en(en_v[2]), .clear(clr_v[2]), .period(period2),
    .period_valid(pv2), .locked(lk2), .fault(ft2)
`ifdef CLOCK_ENABLE_MONITOR_FAULT_COUNT_EN
    , .fault_count(fc2)
`endif
  );

  // Reference model: st 0=SEARCH 1=MEASURE 2=LOCKED 3=FAULT; since = length of
  // the period that an en in the current cycle would close.
  typedef struct {
    int st;
    int good;
    int since;
    int period;
    int fcnt;
    bit pv;
  } model_t;

  model_t m [3];
  int hi_t [3] = '{4, 1, 5};
  int lo_t [3] = '{4, 1, 3};
  int lk_t [3] = '{4, 4, 2};

  function automatic model_t mreset();
    model_t r;
    r.st = 0; r.good = 0; r.since = 1; r.period = 0; r.fcnt = 0; r.pv = 1'b0;
    return r;
  endfunction

  function automatic model_t mstep(model_t s, bit e, bit c, int hi, int lo, int lk);
    model_t r;
    int p;
    bit to;
    bit inr;
    r = s;
    p = s.since;
    to = !e && (p == hi);
    inr = (p >= lo) && (p <= hi);
    r.pv = 1'b0;
    case (s.st)
      0: if (e) begin r.st = 1; r.good = 0; end
      1: begin
        if (to) r.st = 0;
        else if (e) begin
          r.pv = 1'b1;
          if (inr) begin
            r.good = s.good + 1;
            if (r.good == lk) r.st = 2;
          end else r.good = 0;
        end
      end
      2: begin
        if (e) r.pv = 1'b1;
        if (to || (e && !inr)) begin
          r.st = 3;
          if (r.fcnt < 255) r.fcnt = r.fcnt + 1;
        end
      end
      default: begin
        if (c) r.st = 0;
        else if (e) r.pv = 1'b1;
      end
    endcase
    if (r.pv) r.period = (p > hi) ? hi + 1 : p;
    r.since = e ? 1 : ((s.since < 1000) ? s.since + 1 : s.since);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("d0_period", {29'b0, period0}, m[0].period);
    chk("d0_valid",  {31'b0, pv0}, {31'b0, m[0].pv});
    chk("d0_locked", {31'b0, lk0}, (m[0].st == 2) ? 1 : 0);
    chk("d0_fault",  {31'b0, ft0}, (m[0].st == 3) ? 1 : 0);
    chk("d1_period", {30'b0, period1}, m[1].period);
    chk("d1_valid",  {31'b0, pv1}, {31'b0, m[1].pv});
    chk("d1_locked", {31'b0, lk1}, (m[1].st == 2) ? 1 : 0);
    chk("d1_fault",  {31'b0, ft1}, (m[1].st == 3) ? 1 : 0);
    chk("d2_period", {29'b0, period2}, m[2].period);
    chk("d2_valid",  {31'b0, pv2}, {31'b0, m[2].pv});
    chk("d2_locked", {31'b0, lk2}, (m[2].st == 2) ? 1 : 0);
    chk("d2_fault",  {31'b0, ft2}, (m[2].st == 3) ? 1 : 0);
`ifdef CLOCK_ENABLE_MONITOR_FAULT_COUNT_EN
    chk("d0_fcount", {24'b0, fc0}, m[0].fcnt);
    chk("d1_fcount", {24'b0, fc1}, m[1].fcnt);
    chk("d2_fcount", {24'b0, fc2}, m[2].fcnt);
`endif
  endtask

  // One clock: model consumes the current inputs, DUT samples them at the edge.
  task automatic cyc();
    for (int k = 0; k < 3; k++) m[k] = mstep(m[k], en_v[k], clr_v[k], hi_t[k], lo_t[k], lk_t[k]);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic rnd_in(input int k);
    if (k == 1) en_v[k] = ($urandom_range(0, 7) != 0);
    else        en_v[k] = ($urandom_range(0, 3) == 0);
    clr_v[k] = ($urandom_range(0, 7) == 0);
  endtask

  task automatic d0(input bit e, input bit c);
    en_v[0] = e; clr_v[0] = c;
    rnd_in(1); rnd_in(2);
    cyc();
  endtask

  task automatic all_reset_zero(input string tag);
    chk({tag, "_p0"}, {29'b0, period0}, 0);
    chk({tag, "_v0"}, {31'b0, pv0}, 0);
    chk({tag, "_l0"}, {31'b0, lk0}, 0);
    chk({tag, "_f0"}, {31'b0, ft0}, 0);
    chk({tag, "_p1"}, {30'b0, period1}, 0);
    chk({tag, "_l1"}, {31'b0, lk1}, 0);
    chk({tag, "_f1"}, {31'b0, ft1}, 0);
    chk({tag, "_p2"}, {29'b0, period2}, 0);
    chk({tag, "_l2"}, {31'b0, lk2}, 0);
    chk({tag, "_f2"}, {31'b0, ft2}, 0);
`ifdef CLOCK_ENABLE_MONITOR_FAULT_COUNT_EN
    chk({tag, "_fc0"}, {24'b0, fc0}, 0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      en_v[k] = 1'b0; clr_v[k] = 1'b0; m[k] = mreset();
    end
    @(posedge clk);
    #1;
    all_reset_zero("reset");
    #2 rst = 1'b0;

    // Five pulses every 4 cycles lock the strict instance.
    for (int i = 1; i <= 5; i++) begin
      d0(1'b1, 1'b0);
      if (i >= 2) begin
        chk("lockseq_valid", {31'b0, pv0}, 1);
        chk("lockseq_period", {29'b0, period0}, 4);
      end else begin
        chk("first_en_novalid", {31'b0, pv0}, 0);
      end
      if (i == 4) chk("not_yet_locked", {31'b0, lk0}, 0);
      if (i == 5) chk("locked_after_5th", {31'b0, lk0}, 1);
      for (int j = 0; j < ((i == 5) ? 2 : 3); j++) d0(1'b0, 1'b0);
    end

    // Short period while locked.
    d0(1'b1, 1'b0);
    chk("short_period", {29'b0, period0}, 3);
    chk("short_fault", {31'b0, ft0}, 1);
    chk("short_unlocked", {31'b0, lk0}, 0);
`ifdef CLOCK_ENABLE_MONITOR_FAULT_COUNT_EN
    chk("short_fcount", {24'b0, fc0}, 1);
`endif
    d0(1'b0, 1'b0);
    chk("fault_sticky", {31'b0, ft0}, 1);

    // Clear coincident with en: pulse dropped, then relock.
    d0(1'b1, 1'b1);
    chk("clear_fault", {31'b0, ft0}, 0);
    chk("clear_novalid", {31'b0, pv0}, 0);
    for (int j = 0; j < 3; j++) d0(1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      d0(1'b1, 1'b0);
      if (i == 1) chk("after_clear_novalid", {31'b0, pv0}, 0);
      if (i == 5) chk("relocked", {31'b0, lk0}, 1);
      if (i < 5) for (int j = 0; j < 3; j++) d0(1'b0, 1'b0);
    end

    // Withhold en: timeout when cnt reaches 3.
    for (int j = 1; j <= 5; j++) begin
      d0(1'b0, 1'b0);
      if (j == 3) chk("pre_timeout_locked", {31'b0, lk0}, 1);
      if (j == 4) begin
        chk("timeout_fault", {31'b0, ft0}, 1);
        chk("timeout_unlocked", {31'b0, lk0}, 0);
      end
    end
`ifdef CLOCK_ENABLE_MONITOR_FAULT_COUNT_EN
    chk("timeout_fcount", {24'b0, fc0}, 2);
`endif
    d0(1'b0, 1'b1);
    chk("clear_only", {31'b0, ft0}, 0);

    // Asynchronous reset in the middle of MEASURE.
    d0(1'b1, 1'b0);
    for (int j = 0; j < 3; j++) d0(1'b0, 1'b0);
    d0(1'b1, 1'b0);
    d0(1'b0, 1'b0);
    #3 rst = 1'b1;
    for (int k = 0; k < 3; k++) m[k] = mreset();
    #1;
    all_reset_zero("async_rst");
    @(posedge clk);
    #3 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin en_v[k] = 1'b0; clr_v[k] = 1'b0; end

    // TICKS=1 instance: en held high locks after 5 cycles, one gap faults.
    for (int i = 1; i <= 5; i++) begin
      en_v[1] = 1'b1; clr_v[1] = 1'b0;
      rnd_in(0); rnd_in(2);
      cyc();
      if (i == 4) chk("t1_not_locked", {31'b0, lk1}, 0);
    end
    chk("t1_locked", {31'b0, lk1}, 1);
    en_v[1] = 1'b0;
    rnd_in(0); rnd_in(2);
    cyc();
    chk("t1_gap_fault", {31'b0, ft1}, 1);

    // Random streams on all instances.
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 3; k++) rnd_in(k);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
